// File: rtl/window_3_3_gen.sv
// window_3_3_gen: streaming 3x3 sliding-window generator feeding the 3x3 MAC stage.
// Accepts one raster-ordered pixel per valid cycle, keeps two line buffers and
// emits a packed 9-element window one cycle after each qualifying pixel.
//
// Ports:
//   CLK        - clock, rising edge
//   RSTN       - asynchronous active-low reset
//   SOF        - start of frame; with PIX_VALID that pixel is (0,0), alone it clears position
//   PIX_VALID  - PIX_DATA accepted this cycle
//   PIX_DATA   - pixel, row-major raster order
//   WIN_VALID  - Feature holds a new window this cycle
//   Feature    - window, element x = 3*wr + wc at [DATA_WIDTH*x +: DATA_WIDTH]
//                (wr 0 = oldest line, wc 0 = leftmost column)
//   FRAME_DONE - pulse alongside the final window of a frame
//
// Build option: define WIN_STRIDE2_EN for stride-2 window emission (even row and
// column only). Buffering, shifting and latency are the same in both modes.
module window_3_3_gen #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = 28,
  parameter int unsigned IMG_HEIGHT = 28
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      SOF,
  input  logic                      PIX_VALID,
  input  logic [DATA_WIDTH-1:0]     PIX_DATA,
  output logic                      WIN_VALID,
  output logic [DATA_WIDTH*9-1:0]   Feature,
  output logic                      FRAME_DONE
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
  localparam int unsigned WIN_W = DATA_WIDTH * 9;

`ifdef WIN_STRIDE2_EN
  // Last emitted window sits on the largest even row/column.
  localparam int unsigned LAST_ROW = ((IMG_HEIGHT - 1) / 2) * 2;
  localparam int unsigned LAST_COL = ((IMG_WIDTH - 1) / 2) * 2;
`else
  localparam int unsigned LAST_ROW = IMG_HEIGHT - 1;
  localparam int unsigned LAST_COL = IMG_WIDTH - 1;
`endif

  logic [COL_W-1:0]      col_q, col_d, cur_col;
  logic [ROW_W-1:0]      row_q, row_d, cur_row;
  logic [WIN_W-1:0]      win_q, win_d;
  logic                  win_valid_d;
  logic                  frame_done_d;
  logic                  stride_ok;
  logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] new_col [3];

  // Position of the pixel presented this cycle; SOF forces (0,0).
  always_comb begin
    cur_col = SOF ? '0 : col_q;
    cur_row = SOF ? '0 : row_q;
  end

  // New window column: oldest line on top, incoming pixel at the bottom.
  always_comb begin
    new_col[0] = lb1[cur_col];
    new_col[1] = lb0[cur_col];
    new_col[2] = PIX_DATA;
  end

`ifdef WIN_STRIDE2_EN
  assign stride_ok = ~cur_row[0] & ~cur_col[0];
`else
  assign stride_ok = 1'b1;
`endif

  // Next-state: position counters, window shift, output strobes.
  always_comb begin
    col_d        = cur_col;
    row_d        = cur_row;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (PIX_VALID) begin
      if (cur_col == COL_W'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (cur_row == ROW_W'(IMG_HEIGHT - 1)) ? '0 : cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
      end
      for (int wr = 0; wr < 3; wr++) begin
        win_d[DATA_WIDTH*(3*wr)   +: DATA_WIDTH] = win_q[DATA_WIDTH*(3*wr+1) +: DATA_WIDTH];
        win_d[DATA_WIDTH*(3*wr+1) +: DATA_WIDTH] = win_q[DATA_WIDTH*(3*wr+2) +: DATA_WIDTH];
        win_d[DATA_WIDTH*(3*wr+2) +: DATA_WIDTH] = new_col[wr];
      end
      win_valid_d  = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2)) && stride_ok;
      frame_done_d = win_valid_d && (cur_row == ROW_W'(LAST_ROW)) &&
                     (cur_col == COL_W'(LAST_COL));
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      col_q      <= '0;
      row_q      <= '0;
      win_q      <= '0;
      WIN_VALID  <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      win_q      <= win_d;
      WIN_VALID  <= win_valid_d;
      FRAME_DONE <= frame_done_d;
    end
  end

  // Line buffers carry no reset; rows 0/1 of each frame refill them before use.
  always_ff @(posedge CLK) begin
    if (PIX_VALID) begin
      lb1[cur_col] <= lb0[cur_col];
      lb0[cur_col] <= PIX_DATA;
    end
  end

  assign Feature = win_q;

endmodule

// File: tb/tb_window_3_3_gen.sv
// Testbench for window_3_3_gen: a 4x4 instance for frame/gap/reset/SOF scenarios
// and a 5x5 instance for the stride scenario. Expected windows are built from a
// bench-side image copy and checked through a scoreboard queue.
module tb_window_3_3_gen;

`ifdef WIN_STRIDE2_EN
  localparam int STRIDE = 2;
`else
  localparam int STRIDE = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        sof_a, pv_a, wv_a, fd_a;
  logic [7:0]  pd_a;
  logic [71:0] feat_a;
  logic        sof_b, pv_b, wv_b, fd_b;
  logic [7:0]  pd_b;
  logic [71:0] feat_b;

  window_3_3_gen #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
    .CLK(clk), .RSTN(rstn), .SOF(sof_a), .PIX_VALID(pv_a), .PIX_DATA(pd_a),
    .WIN_VALID(wv_a), .Feature(feat_a), .FRAME_DONE(fd_a));

  window_3_3_gen #(.DATA_WIDTH(8), .IMG_WIDTH(5), .IMG_HEIGHT(5)) dut_b (
    .CLK(clk), .RSTN(rstn), .SOF(sof_b), .PIX_VALID(pv_b), .PIX_DATA(pd_b),
    .WIN_VALID(wv_b), .Feature(feat_b), .FRAME_DONE(fd_b));

  typedef struct packed {
    logic [71:0] f;
    logic        fd;
    int          cyc;
  } exp_t;

  exp_t        exp_a[$], exp_b[$];
  logic [71:0] obs_a[$], obs_b[$];
  int          fd_cnt_a = 0, fd_cnt_b = 0;
  int          errors = 0, checks = 0;
  int          cyc = 0;
  logic [7:0]  img_a [4][4];
  logic [7:0]  img_b [5][5];

  function automatic int nwin(input int h, input int w);
    return (STRIDE == 1) ? (h - 2) * (w - 2) : ((h - 1) / 2) * ((w - 1) / 2);
  endfunction

  function automatic int last_idx(input int n);
    return (STRIDE == 1) ? n - 1 : ((n - 1) / 2) * 2;
  endfunction

  function automatic bit emits(input int r, input int c);
    return (r >= 2) && (c >= 2) && ((STRIDE == 1) || ((r % 2 == 0) && (c % 2 == 0)));
  endfunction

  // Scoreboard side: runs once per cycle, after the active edge.
  task automatic monitor();
    exp_t e;
    checks++;
    if (wv_a === 1'b1) begin
      if (pv_a !== 1'b1) begin
        errors++;
        $display("FAIL idle_valid_a: WIN_VALID=1 with no accepted pixel, required 0");
      end
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL extra_window_a: got %h, required no window", feat_a);
      end else begin
        e = exp_a.pop_front();
        if ({feat_a, fd_a} !== {e.f, e.fd} || cyc != e.cyc + 1) begin
          errors++;
          $display("FAIL window_a: got %h fd=%b cyc=%0d, required %h fd=%b cyc=%0d",
                   feat_a, fd_a, cyc, e.f, e.fd, e.cyc + 1);
        end
      end
      obs_a.push_back(feat_a);
      if (fd_a === 1'b1) fd_cnt_a++;
    end else if (fd_a !== 1'b0 || wv_a !== 1'b0) begin
      errors++;
      $display("FAIL strobe_a: WIN_VALID=%b FRAME_DONE=%b, required 0 0", wv_a, fd_a);
    end
    checks++;
    if (wv_b === 1'b1) begin
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL extra_window_b: got %h, required no window", feat_b);
      end else begin
        e = exp_b.pop_front();
        if ({feat_b, fd_b} !== {e.f, e.fd} || cyc != e.cyc + 1) begin
          errors++;
          $display("FAIL window_b: got %h fd=%b cyc=%0d, required %h fd=%b cyc=%0d",
                   feat_b, fd_b, cyc, e.f, e.fd, e.cyc + 1);
        end
      end
      obs_b.push_back(feat_b);
      if (fd_b === 1'b1) fd_cnt_b++;
    end else if (fd_b !== 1'b0 || wv_b !== 1'b0) begin
      errors++;
      $display("FAIL strobe_b: WIN_VALID=%b FRAME_DONE=%b, required 0 0", wv_b, fd_b);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
    monitor();
  endtask

  task automatic idle(input int n);
    pv_a = 1'b0; sof_a = 1'b0; pv_b = 1'b0; sof_b = 1'b0;
    repeat (n) tick();
  endtask

  // Present one pixel to instance d (0: 4x4, 1: 5x5) and queue its window if any.
  task automatic drive_px(input int d, input int r, input int c, input logic [7:0] v,
                          input logic s, input int gap);
    exp_t e;
    int   n;
    if (gap > 0) idle(gap);
    n = (d == 0) ? 4 : 5;
    if (d == 0) img_a[r][c] = v; else img_b[r][c] = v;
    e.f   = '0;
    e.cyc = cyc;
    e.fd  = (r == last_idx(n)) && (c == last_idx(n));
    if (emits(r, c)) begin
      for (int wr = 0; wr < 3; wr++)
        for (int wc = 0; wc < 3; wc++)
          e.f[8*(3*wr+wc) +: 8] = (d == 0) ? img_a[r-2+wr][c-2+wc] : img_b[r-2+wr][c-2+wc];
    end
    if (d == 0) begin
      pv_a = 1'b1; sof_a = s; pd_a = v; pv_b = 1'b0; sof_b = 1'b0;
      if (emits(r, c)) exp_a.push_back(e);
    end else begin
      pv_b = 1'b1; sof_b = s; pd_b = v; pv_a = 1'b0; sof_a = 1'b0;
      if (emits(r, c)) exp_b.push_back(e);
    end
    tick();
  endtask

  task automatic frame(input int d, input int base, input logic s, input int gapmax);
    int n;
    n = (d == 0) ? 4 : 5;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        drive_px(d, r, c, 8'(n * r + c + base), s && (r == 0) && (c == 0),
                 (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle(3);
    checks++;
    if ({wv_a, fd_a, feat_a, wv_b, fd_b, feat_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got a=%b%b%h b=%b%b%h, required all 0",
               wv_a, fd_a, feat_a, wv_b, fd_b, feat_b);
    end
    rstn = 1'b1;
    idle(2);
  endtask

  task automatic test_basic(input int gapmax, input string name);
    int n0, f0;
    n0 = obs_a.size(); f0 = fd_cnt_a;
    frame(0, 1, 1'b1, gapmax);
    idle(3);
    checks++;
    if (obs_a.size() - n0 != nwin(4, 4) || fd_cnt_a - f0 != 1) begin
      errors++;
      $display("FAIL %s_count: got %0d windows %0d done, required %0d and 1",
               name, obs_a.size() - n0, fd_cnt_a - f0, nwin(4, 4));
    end
    checks++;
    if (((obs_a.size() > n0) ? obs_a[n0] : 72'hx) !== 72'h0B0A09070605030201) begin
      errors++;
      $display("FAIL %s_first: got %h, required 0b0a09070605030201", name,
               (obs_a.size() > n0) ? obs_a[n0] : 72'hx);
    end
    checks++;
    if (((obs_a.size() > 0) ? obs_a[$] : 72'hx) !==
        ((STRIDE == 1) ? 72'h100F0E0C0B0A080706 : 72'h0B0A09070605030201)) begin
      errors++;
      $display("FAIL %s_last: got %h, required per stride", name,
               (obs_a.size() > 0) ? obs_a[$] : 72'hx);
    end
  endtask

  task automatic test_back_to_back();
    int n0, f0;
    n0 = obs_a.size(); f0 = fd_cnt_a;
    frame(0, 1, 1'b1, 0);
    frame(0, 8'h41, 1'b0, 0);
    idle(3);
    checks++;
    if (obs_a.size() - n0 != 2 * nwin(4, 4) || fd_cnt_a - f0 != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d windows %0d done, required %0d and 2",
               obs_a.size() - n0, fd_cnt_a - f0, 2 * nwin(4, 4));
    end
    checks++;
    if (((obs_a.size() > n0 + nwin(4, 4)) ? obs_a[n0 + nwin(4, 4)] : 72'hx) !==
        72'h4B4A49474645434241) begin
      errors++;
      $display("FAIL b2b_wrap: got %h, required 4b4a49474645434241",
               (obs_a.size() > n0 + nwin(4, 4)) ? obs_a[n0 + nwin(4, 4)] : 72'hx);
    end
  endtask

  task automatic test_reset_mid();
    int n0, f0;
    for (int i = 0; i < 9; i++) drive_px(0, i / 4, i % 4, 8'(i + 1), i == 0, 0);
    pv_a = 1'b0;
    #1 rstn = 1'b0;
    #1;
    checks++;
    if ({wv_a, fd_a, feat_a} !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: got %b %b %h, required 0 0 0", wv_a, fd_a, feat_a);
    end
    idle(2);
    checks++;
    if ({wv_a, fd_a, feat_a} !== '0 || exp_a.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_hold: got %b %b %h pending=%0d, required 0 0 0 0",
               wv_a, fd_a, feat_a, exp_a.size());
    end
    rstn = 1'b1;
    idle(1);
    n0 = obs_a.size(); f0 = fd_cnt_a;
    frame(0, 1, 1'b0, 0);
    idle(3);
    checks++;
    if (obs_a.size() - n0 != nwin(4, 4) || fd_cnt_a - f0 != 1) begin
      errors++;
      $display("FAIL reset_mid_frame: got %0d windows %0d done, required %0d and 1",
               obs_a.size() - n0, fd_cnt_a - f0, nwin(4, 4));
    end
  endtask

  task automatic test_sof();
    int n0, f0;
    n0 = obs_a.size(); f0 = fd_cnt_a;
    for (int i = 0; i < 6; i++) drive_px(0, i / 4, i % 4, 8'(8'hA0 + i), i == 0, 0);
    frame(0, 1, 1'b1, 0);
    idle(2);
    checks++;
    if (obs_a.size() - n0 != nwin(4, 4) || fd_cnt_a - f0 != 1) begin
      errors++;
      $display("FAIL sof_valid: got %0d windows %0d done, required %0d and 1",
               obs_a.size() - n0, fd_cnt_a - f0, nwin(4, 4));
    end
    // SOF without a pixel only clears the position.
    n0 = obs_a.size(); f0 = fd_cnt_a;
    for (int i = 0; i < 5; i++) drive_px(0, i / 4, i % 4, 8'(8'hC0 + i), i == 0, 0);
    pv_a = 1'b0; sof_a = 1'b1;
    tick();
    sof_a = 1'b0;
    frame(0, 1, 1'b0, 0);
    idle(2);
    checks++;
    if (obs_a.size() - n0 != nwin(4, 4) || fd_cnt_a - f0 != 1) begin
      errors++;
      $display("FAIL sof_alone: got %0d windows %0d done, required %0d and 1",
               obs_a.size() - n0, fd_cnt_a - f0, nwin(4, 4));
    end
  endtask

  task automatic test_stride();
    int          n0, f0;
    logic [71:0] second;
    n0 = obs_b.size(); f0 = fd_cnt_b;
    second = (STRIDE == 1) ? 72'h0E0D0C090807040302 : 72'h0F0E0D0A0908050403;
    frame(1, 1, 1'b1, 0);
    idle(3);
    checks++;
    if (obs_b.size() - n0 != nwin(5, 5) || fd_cnt_b - f0 != 1) begin
      errors++;
      $display("FAIL stride_count: got %0d windows %0d done, required %0d and 1",
               obs_b.size() - n0, fd_cnt_b - f0, nwin(5, 5));
    end
    checks++;
    if (((obs_b.size() > n0) ? obs_b[n0] : 72'hx) !== 72'h0D0C0B080706030201) begin
      errors++;
      $display("FAIL stride_first: got %h, required 0d0c0b080706030201",
               (obs_b.size() > n0) ? obs_b[n0] : 72'hx);
    end
    checks++;
    if (((obs_b.size() > n0 + 1) ? obs_b[n0 + 1] : 72'hx) !== second) begin
      errors++;
      $display("FAIL stride_second: got %h, required %h",
               (obs_b.size() > n0 + 1) ? obs_b[n0 + 1] : 72'hx, second);
    end
    checks++;
    if (((obs_b.size() > 0) ? obs_b[$] : 72'hx) !== 72'h1918171413120F0E0D) begin
      errors++;
      $display("FAIL stride_last: got %h, required 1918171413120f0e0d",
               (obs_b.size() > 0) ? obs_b[$] : 72'hx);
    end
  endtask

  initial begin
    sof_a = 1'b0; pv_a = 1'b0; pd_a = '0;
    sof_b = 1'b0; pv_b = 1'b0; pd_b = '0;
    rstn  = 1'b0;
    test_reset();
    test_basic(0, "basic");
    test_basic(3, "gaps");
    test_back_to_back();
    test_reset_mid();
    test_sof();
    test_stride();
    checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      errors++;
      $display("FAIL pending_windows: got %0d and %0d outstanding, required 0 and 0",
               exp_a.size(), exp_b.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
